rv32i_inst_encoder: RTL and testbench
=====================================

# rv32i_inst_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields (opcode, registers, funct3/funct7, 32-bit immediate) over a valid/ready handshake. Emits the packed 32-bit instruction word with its byte address, one registered stage later. Sits between the test-program/boot-image generator and the instruction-memory writer. It is the inverse of the field-extraction decode used in the core front end.

## Interface
- `ADDR_WIDTH`, default 12: width of the byte-address counter `out_addr`.
- `BASE_ADDR`, default 0: address given to the first instruction after reset or restart.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `restart` in 1: synchronous; reloads the address counter to `BASE_ADDR` and clears `err_sticky`.
- `in_valid` in 1: input fields valid.
- `in_ready` out 1: encoder can accept.
- `in_opcode` in 7: RV32I opcode.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register indices.
- `in_funct3` in 3.
- `in_funct7` in 7.
- `in_imm` in 32: immediate as the architectural signed value. For U-type, the low 12 bits are zero.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts.
- `out_inst` out 32: encoded instruction.
- `out_addr` out `ADDR_WIDTH`: byte address of `out_inst`.
- `out_error` out 1: `out_inst` is unencodable and has been replaced by NOP (0x00000013).
- `err_sticky` out 1: some error since the last reset or restart.
- `inst_count` out 32: number of accepted instructions, saturating at 0xFFFFFFFF.

## Operation
- Encoding by opcode:
  - OP (0x33): funct7|rs2|rs1|funct3|rd|op.
  - IMM (0x13), LOAD (0x03), JALR (0x67), SYSTEM (0x73): imm[11:0]|rs1|funct3|rd|op.
    - Exception, IMM with funct3 1 or 5: bits [31:25] = funct7 and bits [24:20] = imm[4:0].
  - STORE (0x23): imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - LUI (0x37), AUIPC (0x17): imm[31:12]|rd|op.
  - JAL (0x6F): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - BRANCH (0x63): imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
- Error conditions (any one sets `out_error`):
  - Unlisted opcode.
  - OP with funct7 other than 0x00 or 0x20.
  - IMM shift with funct7 other than 0x00 or 0x20, or imm[31:5] ≠ 0.
  - I-type or S-type with imm[31:12] not all equal to imm[11].
  - U-type with imm[11:0] ≠ 0.
  - B-type with imm[0] = 1, or imm[31:13] not all equal to imm[12].
  - J-type with imm[0] = 1, or imm[31:21] not all equal to imm[20].
- On error: `out_inst` = 0x00000013 and `out_error` = 1. `out_addr` still advances as for a good instruction.
- Address generation:
  - Internal `next_addr` is loaded into `out_addr` on every input handshake, then incremented by 4.
  - The counter wraps modulo 2^`ADDR_WIDTH`.
- `restart` is honoured in any cycle:
  - `next_addr` ← `BASE_ADDR` and `err_sticky` ← 0.
  - If an input handshake occurs in the same cycle, that instruction gets `BASE_ADDR`, `next_addr` becomes `BASE_ADDR`+4, and its own error, if any, sets `err_sticky`. Setting wins over clearing.
  - `restart` does not touch `out_valid`/`out_inst`/`out_addr`/`out_error`, and does not clear `inst_count`.

## Timing
- Single output register stage; `in_ready` = !`out_valid` || `out_ready`, combinational from `out_ready`.
- Latency is 1 cycle from input handshake to `out_valid`. Throughput is 1 instruction per cycle under continuous `out_ready`.
- Output hold: while `out_valid` && !`out_ready`, the values `out_inst`, `out_addr` and `out_error` hold stable and no input is accepted.
- Same-cycle handshakes: when input and output handshakes occur in the same cycle, the register reloads with the new instruction and `out_valid` stays 1.
- Reset values:
  - `out_valid` 0.
  - `out_inst` 0.
  - `out_addr` `BASE_ADDR`.
  - `out_error` 0.
  - `err_sticky` 0.
  - `inst_count` 0.
  - `next_addr` `BASE_ADDR`.
- Reset asserted mid-stream drops any held output immediately (asynchronously). The first instruction after deassertion gets `BASE_ADDR`.

## Test plan
- `addi x1,x0,5` (op 0x13, rd 1, f3 0, imm 5) then `sub x3,x1,x2` (op 0x33, f7 0x20) with `out_ready`=1 -> 0x00500093 @0, then 0x402081B3 @4, each 1 cycle after acceptance; `inst_count`=2.
- `sw x2,-4(x1)` (imm 0xFFFFFFFC), `beq x1,x2,-8`, `jal x1,2048` -> 0xFE20AE23, 0xFE208CE3, 0x001000EF; `out_error`=0 for all three.
- `addi` with imm 0x800, then `beq` with imm 3 -> both emit 0x00000013 with `out_error`=1, and `err_sticky`=1. Then pulse `restart` alone -> `err_sticky`=0 and the next instruction gets address 0.
- Backpressure test, `in_valid` held high throughout:
  - Hold `out_ready`=0 for 3 cycles with a second instruction pending -> `in_ready`=0, outputs stable.
  - Release -> addresses 0 and 4 delivered back-to-back with no loss or duplication.
- `ADDR_WIDTH`=4, five consecutive instructions -> `out_addr` 0, 4, 8, 12, 0.
- Assert `rst` while `out_valid`=1 and `out_ready`=0 -> `out_valid` drops without waiting for a clock edge. After release the next instruction appears at `BASE_ADDR` with `inst_count`=1.

Source files
------------

// File: rtl/rv32i_inst_encoder.sv
// rv32i_inst_encoder: packs decoded RV32I fields into 32-bit instruction words,
// tagging each with a byte address; unencodable inputs become NOP with out_error.
module rv32i_inst_encoder #(
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [31:0]           in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_error,
    output logic                  err_sticky,
    output logic [31:0]           inst_count
);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] enc;
    logic bad;
    logic f7_ok, i_ok, shift, in_hs;
    logic [ADDR_WIDTH-1:0] next_addr, cur_addr;

    assign f7_ok = in_funct7 == 7'h00 || in_funct7 == 7'h20;
    assign i_ok = in_imm[31:12] == {20{in_imm[11]}};
    assign shift = in_funct3 == 3'd1 || in_funct3 == 3'd5;
    assign in_ready = !out_valid || out_ready;
    assign in_hs = in_valid && in_ready;
    assign cur_addr = restart ? BASE : next_addr;

    always_comb begin
        enc = NOP;
        bad = 1'b1;
        case (in_opcode)
            7'h33: begin
                enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                bad = !f7_ok;
            end
            7'h13: begin
                enc = shift ? {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode}
                            : {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                bad = shift ? (!f7_ok || |in_imm[31:5]) : !i_ok;
            end
            7'h03, 7'h67, 7'h73: begin
                enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                bad = !i_ok;
            end
            7'h23: begin
                enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                bad = !i_ok;
            end
            7'h37, 7'h17: begin
                enc = {in_imm[31:12], in_rd, in_opcode};
                bad = |in_imm[11:0];
            end
            7'h6f: begin
                enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                bad = in_imm[0] || in_imm[31:21] != {11{in_imm[20]}};
            end
            7'h63: begin
                enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode};
                bad = in_imm[0] || in_imm[31:13] != {19{in_imm[12]}};
            end
            default: ;
        endcase
    end

    // restart and a same-cycle handshake combine: the new instruction takes BASE and may re-set the sticky flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_inst   <= '0;
            out_addr   <= BASE;
            out_error  <= 1'b0;
            err_sticky <= 1'b0;
            inst_count <= '0;
            next_addr  <= BASE;
        end else begin
            if (in_hs) begin
                out_valid  <= 1'b1;
                out_inst   <= bad ? NOP : enc;
                out_addr   <= cur_addr;
                out_error  <= bad;
                inst_count <= inst_count == 32'hFFFF_FFFF ? inst_count : inst_count + 32'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            next_addr  <= in_hs ? cur_addr + ADDR_WIDTH'(4) : cur_addr;
            err_sticky <= (in_hs && bad) || (err_sticky && !restart);
        end
    end
endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// tb_rv32i_inst_encoder: directed test-plan cases plus random stimulus against a
// field-level reference model; a second instance with a 4-bit address checks wrap.
module tb_rv32i_inst_encoder;
    logic clk = 0, rst = 1, restart = 0, in_valid = 0, out_ready = 1;
    logic [6:0] in_opcode = 0, in_funct7 = 0;
    logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
    logic [2:0] in_funct3 = 0;
    logic [31:0] in_imm = 0;
    logic in_ready, out_valid, out_error, err_sticky;
    logic [31:0] out_inst, inst_count;
    logic [11:0] out_addr;
    logic in_ready4, out_valid4, out_error4, err_sticky4;
    logic [31:0] out_inst4, inst_count4;
    logic [3:0] out_addr4;

    int total = 0, bad = 0;
    bit m_valid = 0, m_err = 0, m_sticky = 0;
    logic [31:0] m_inst = 0, m_count = 0;
    int unsigned m_addr = 0, m_next = 0;

    rv32i_inst_encoder dut (
        .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .out_error(out_error), .err_sticky(err_sticky), .inst_count(inst_count)
    );

    rv32i_inst_encoder #(.ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready4),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid4), .out_ready(out_ready), .out_inst(out_inst4), .out_addr(out_addr4),
        .out_error(out_error4), .err_sticky(err_sticky4), .inst_count(inst_count4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void ref_enc(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                    input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                                    output logic [31:0] w, output bit e);
        int s;
        bit f7ok;
        s = imm;
        f7ok = f7 == 0 || f7 == 32;
        w = 0;
        e = 0;
        case (op)
            7'h33: begin e = !f7ok; w = {f7, rs2, rs1, f3, rd, op}; end
            7'h13, 7'h03, 7'h67, 7'h73:
                if (op == 7'h13 && (f3 == 1 || f3 == 5)) begin
                    e = !f7ok || imm > 31;
                    w = {f7, imm[4:0], rs1, f3, rd, op};
                end else begin
                    e = s < -2048 || s > 2047;
                    w = {imm[11:0], rs1, f3, rd, op};
                end
            7'h23: begin e = s < -2048 || s > 2047; w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; end
            7'h37, 7'h17: begin e = imm % 4096 != 0; w = {imm[31:12], rd, op}; end
            7'h6f: begin
                e = imm[0] || s < -1048576 || s > 1048575;
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            7'h63: begin
                e = imm[0] || s < -4096 || s > 4095;
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            end
            default: e = 1;
        endcase
        if (e) w = 32'h13;
    endfunction

    // one clock: check in_ready before the edge, advance the model, then check all outputs
    task automatic cycle();
        logic [31:0] w;
        bit e, rdy, hs;
        #1;
        rdy = !m_valid || out_ready;
        hs = in_valid && rdy;
        check("in_ready", in_ready, rdy);
        check("in_ready4", in_ready4, rdy);
        ref_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, w, e);
        @(posedge clk);
        #1;
        if (hs) begin
            m_inst = w;
            m_err = e;
            m_addr = restart ? 0 : m_next;
            m_next = m_addr + 4;
            m_valid = 1;
            if (m_count != 32'hFFFF_FFFF) m_count++;
        end else begin
            if (out_ready) m_valid = 0;
            if (restart) m_next = 0;
        end
        m_sticky = (hs && e) || (m_sticky && !restart);
        check("out_valid", out_valid, m_valid);
        check("out_inst", out_inst, m_inst);
        check("out_addr", out_addr, m_addr % 4096);
        check("out_error", out_error, m_err);
        check("err_sticky", err_sticky, m_sticky);
        check("inst_count", inst_count, m_count);
        check("out_valid4", out_valid4, m_valid);
        check("out_inst4", out_inst4, m_inst);
        check("out_addr4", out_addr4, m_addr % 16);
        check("err_sticky4", err_sticky4, m_sticky);
    endtask

    task automatic issue(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        in_valid = 1;
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        cycle();
        in_valid = 0;
    endtask

    task automatic pulse_restart();
        restart = 1;
        cycle();
        restart = 0;
    endtask

    initial begin
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h63};
        logic [31:0] r;
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_inst", out_inst, 0);
        check("rst_addr", out_addr, 0);
        check("rst_error", out_error, 0);
        check("rst_sticky", err_sticky, 0);
        check("rst_count", inst_count, 0);
        @(negedge clk);
        rst = 0;

        issue(7'h13, 1, 0, 0, 0, 0, 5);
        check("addi_inst", out_inst, 32'h00500093);
        check("addi_addr", out_addr, 0);
        issue(7'h33, 3, 1, 2, 0, 7'h20, 0);
        check("sub_inst", out_inst, 32'h402081B3);
        check("sub_addr", out_addr, 4);
        check("count2", inst_count, 2);
        issue(7'h23, 0, 1, 2, 2, 0, 32'hFFFFFFFC);
        check("sw_inst", out_inst, 32'hFE20AE23);
        check("sw_err", out_error, 0);
        issue(7'h63, 0, 1, 2, 0, 0, 32'hFFFFFFF8);
        check("beq_inst", out_inst, 32'hFE208CE3);
        check("beq_err", out_error, 0);
        issue(7'h6f, 1, 0, 0, 0, 0, 2048);
        check("jal_inst", out_inst, 32'h001000EF);
        check("jal_err", out_error, 0);

        issue(7'h13, 1, 0, 0, 0, 0, 32'h800);
        check("bad_addi_inst", out_inst, 32'h13);
        check("bad_addi_err", out_error, 1);
        issue(7'h63, 0, 1, 2, 0, 0, 3);
        check("bad_beq_inst", out_inst, 32'h13);
        check("bad_beq_err", out_error, 1);
        check("sticky_set", err_sticky, 1);
        pulse_restart();
        check("sticky_clr", err_sticky, 0);
        issue(7'h13, 1, 0, 0, 0, 0, 5);
        check("restart_addr", out_addr, 0);

        pulse_restart();
        out_ready = 0;
        issue(7'h13, 2, 0, 0, 0, 0, 7);
        check("bp_a_valid", out_valid, 1);
        in_valid = 1;
        in_imm = 9;
        repeat (3) cycle();
        check("bp_ready", in_ready, 0);
        check("bp_hold_addr", out_addr, 0);
        check("bp_hold_inst", out_inst, 32'h00700113);
        out_ready = 1;
        cycle();
        in_valid = 0;
        check("bp_b_addr", out_addr, 4);
        check("bp_b_inst", out_inst, 32'h00900113);
        cycle();
        check("bp_drain", out_valid, 0);

        pulse_restart();
        for (int i = 0; i < 5; i++) begin
            issue(7'h33, 5, 6, 7, 0, 0, 0);
            check("wrap_addr4", out_addr4, (i * 4) % 16);
        end

        out_ready = 0;
        issue(7'h13, 1, 0, 0, 0, 0, 1);
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_valid4", out_valid4, 0);
        m_valid = 0; m_inst = 0; m_err = 0; m_sticky = 0; m_count = 0; m_addr = 0; m_next = 0;
        @(negedge clk);
        rst = 0;
        out_ready = 1;
        issue(7'h13, 1, 0, 0, 0, 0, 1);
        check("post_rst_addr", out_addr, 0);
        check("post_rst_count", inst_count, 1);

        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            restart = $urandom_range(0, 19) == 0;
            in_opcode = $urandom_range(0, 9) == 0 ? 7'($urandom) : ops[$urandom_range(0, 9)];
            in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
            in_funct3 = 3'($urandom);
            in_funct7 = $urandom_range(0, 3) == 0 ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
            case ($urandom_range(0, 5))
                0: in_imm = {{20{r[11]}}, r[11:0]};
                1: in_imm = {{19{r[12]}}, r[12:1], 1'b0};
                2: in_imm = {{11{r[20]}}, r[20:1], 1'b0};
                3: in_imm = {r[31:12], 12'b0};
                4: in_imm = $urandom_range(0, 40);
                default: in_imm = r;
            endcase
            cycle();
        end
        restart = 0;
        in_valid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
